// File: rtl/johnson_phase_monitor.sv
// johnson_phase_monitor
// Watches the code of an upstream 4-bit Johnson counter. Every cycle it
// decodes the code to a one-hot phase, checks that the counter only holds or
// steps forward by one phase, and keeps a lock/fault state machine plus a
// revolution counter that is active only while locked.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_SEARCH | waiting for LOCK_CNT consecutive legal advances (holds allowed)
// ST_LOCKED | counter tracks cleanly; 7->0 advances count revolutions
// ST_FAULT  | illegal code or sequence error seen while locked; wait clr_err
module johnson_phase_monitor #(
    parameter int LOCK_CNT = 8,
    parameter int REV_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       jc_in,
    input  logic             clr_err,
    output logic [7:0]       phase,
    output logic             phase_vld,
    output logic             locked,
    output logic             err_illegal,
    output logic             err_seq,
    output logic [REV_W-1:0] rev_cnt,
    output logic             rev_pulse
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_LOCKED = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    // Lock threshold as a 4-bit terminal count for the advance counter.
    localparam logic [3:0]       LOCK_TC = 4'(LOCK_CNT);
    localparam logic [REV_W-1:0] REV_ONE = {{(REV_W-1){1'b0}}, 1'b1};

    state_t     state;
    state_t     state_nxt;
    logic [3:0] adv_cnt;
    logic [3:0] adv_cnt_nxt;
    logic [3:0] adv_cnt_inc;

    logic [2:0] prev_idx;
    logic       prev_vld;
    logic [2:0] prev_inc;

    logic [2:0] smp_idx;
    logic       smp_legal;
    logic       smp_adv;
    logic       smp_seqerr;
    logic       smp_bad;
    logic       rev_hit;

    // Decode the incoming Johnson code to a phase index; anything else is illegal.
    always_comb begin
        smp_idx   = 3'd0;
        smp_legal = 1'b1;
        case (jc_in)
            4'b0000: smp_idx = 3'd0;
            4'b1000: smp_idx = 3'd1;
            4'b1100: smp_idx = 3'd2;
            4'b1110: smp_idx = 3'd3;
            4'b1111: smp_idx = 3'd4;
            4'b0111: smp_idx = 3'd5;
            4'b0011: smp_idx = 3'd6;
            4'b0001: smp_idx = 3'd7;
            default: smp_legal = 1'b0;
        endcase
    end

    // Classify a legal sample against the previous one. Without a valid
    // previous sample nothing can be an advance or a sequence error.
    always_comb begin
        prev_inc    = prev_idx + 3'd1;
        adv_cnt_inc = adv_cnt + 4'd1;
        smp_adv     = smp_legal & prev_vld & (smp_idx == prev_inc);
        smp_seqerr  = smp_legal & prev_vld & (smp_idx != prev_idx) & (smp_idx != prev_inc);
        smp_bad     = ~smp_legal | smp_seqerr;
    end

    // Next-state logic for the lock FSM, the advance counter and revolution hits.
    always_comb begin
        state_nxt   = state;
        adv_cnt_nxt = adv_cnt;
        rev_hit     = 1'b0;
        case (state)
            ST_SEARCH: begin
                // An error on the qualifying sample wins: counter clears, no lock.
                if (smp_bad) begin
                    adv_cnt_nxt = 4'd0;
                end else if (smp_adv) begin
                    if (adv_cnt_inc == LOCK_TC) begin
                        state_nxt   = ST_LOCKED;
                        adv_cnt_nxt = 4'd0;
                    end else begin
                        adv_cnt_nxt = adv_cnt_inc;
                    end
                end
            end
            ST_LOCKED: begin
                adv_cnt_nxt = 4'd0;
                if (smp_bad) begin
                    state_nxt = ST_FAULT;
                end else if (smp_adv && (prev_idx == 3'd7)) begin
                    rev_hit = 1'b1;
                end
            end
            ST_FAULT: begin
                // The exit sample never counts toward lock.
                adv_cnt_nxt = 4'd0;
                if (clr_err) begin
                    state_nxt = ST_SEARCH;
                end
            end
            default: begin
                state_nxt   = ST_SEARCH;
                adv_cnt_nxt = 4'd0;
            end
        endcase
    end

    // FSM state, advance counter and the registered locked indication.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_SEARCH;
            adv_cnt <= 4'd0;
            locked  <= 1'b0;
        end else begin
            state   <= state_nxt;
            adv_cnt <= adv_cnt_nxt;
            locked  <= (state_nxt == ST_LOCKED);
        end
    end

    // Previous-sample tracking used to classify the next sample.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_idx <= 3'd0;
            prev_vld <= 1'b0;
        end else if (smp_legal) begin
            prev_idx <= smp_idx;
            prev_vld <= 1'b1;
        end else begin
            prev_vld <= 1'b0;
        end
    end

    // Registered one-hot phase output and its valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            phase     <= 8'd0;
            phase_vld <= 1'b0;
        end else if (smp_legal) begin
            phase     <= 8'd1 << smp_idx;
            phase_vld <= 1'b1;
        end else begin
            phase     <= 8'd0;
            phase_vld <= 1'b0;
        end
    end

    // Sticky error flags; a detection in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_illegal <= 1'b0;
            err_seq     <= 1'b0;
        end else begin
            err_illegal <= (err_illegal & ~clr_err) | ~smp_legal;
            err_seq     <= (err_seq & ~clr_err) | smp_seqerr;
        end
    end

    // Revolution counter and strobe; only reset clears the count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rev_cnt   <= '0;
            rev_pulse <= 1'b0;
        end else begin
            rev_pulse <= rev_hit;
            if (rev_hit) begin
                rev_cnt <= rev_cnt + REV_ONE;
            end
        end
    end

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Self-checking bench for johnson_phase_monitor: directed scenarios plus a
// randomized run, all compared against a behavioural model of the monitor.
module tb_johnson_phase_monitor;

    localparam int LOCK_CNT = 8;

    logic       clk;
    logic       rst;
    logic [3:0] jc_in;
    logic       clr_err;

    logic [7:0] phase;
    logic       phase_vld;
    logic       locked;
    logic       err_illegal;
    logic       err_seq;
    logic [7:0] rev_cnt;
    logic       rev_pulse;

    logic [7:0] phase2;
    logic       phase_vld2;
    logic       locked2;
    logic       err_illegal2;
    logic       err_seq2;
    logic [1:0] rev_cnt2;
    logic       rev_pulse2;

    int checks = 0;
    int passed = 0;

    // model state
    int         m_mode;      // 0 search, 1 locked, 2 fault
    int         m_run;
    int         m_pi;
    bit         m_pv;
    logic [7:0] e_phase;
    logic       e_vld, e_locked, e_ill, e_seq, e_pulse;
    logic [7:0] e_rev;
    logic [1:0] e_rev2;

    int cur_idx;

    johnson_phase_monitor #(.LOCK_CNT(LOCK_CNT), .REV_W(8)) dut (
        .clk(clk), .rst(rst), .jc_in(jc_in), .clr_err(clr_err),
        .phase(phase), .phase_vld(phase_vld), .locked(locked),
        .err_illegal(err_illegal), .err_seq(err_seq),
        .rev_cnt(rev_cnt), .rev_pulse(rev_pulse)
    );

    johnson_phase_monitor #(.LOCK_CNT(LOCK_CNT), .REV_W(2)) dut2 (
        .clk(clk), .rst(rst), .jc_in(jc_in), .clr_err(clr_err),
        .phase(phase2), .phase_vld(phase_vld2), .locked(locked2),
        .err_illegal(err_illegal2), .err_seq(err_seq2),
        .rev_cnt(rev_cnt2), .rev_pulse(rev_pulse2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] code_of(input int i);
        case (i % 8)
            0: return 4'b0000;
            1: return 4'b1000;
            2: return 4'b1100;
            3: return 4'b1110;
            4: return 4'b1111;
            5: return 4'b0111;
            6: return 4'b0011;
            default: return 4'b0001;
        endcase
    endfunction

    function automatic logic [3:0] illegal_code(input int k);
        case (k % 8)
            0: return 4'b0100;
            1: return 4'b0010;
            2: return 4'b0110;
            3: return 4'b1010;
            4: return 4'b0101;
            5: return 4'b1001;
            6: return 4'b1011;
            default: return 4'b1101;
        endcase
    endfunction

    function automatic int idx_of(input logic [3:0] c);
        for (int i = 0; i < 8; i++)
            if (code_of(i) == c) return i;
        return -1;
    endfunction

    function automatic logic [22:0] exp_vec();
        return {e_phase, e_vld, e_locked, e_ill, e_seq, e_rev, e_pulse, e_rev2};
    endfunction

    function automatic logic [22:0] obs_vec();
        return {phase, phase_vld, locked, err_illegal, err_seq, rev_cnt, rev_pulse, rev_cnt2};
    endfunction

    // Reference behaviour for one sampled cycle.
    task automatic model(input logic [3:0] c, input logic clr, input logic r);
        int  k;
        bit  legal, adv, seq, bad;
        if (!r) begin
            m_mode = 0; m_run = 0; m_pi = 0; m_pv = 0;
            e_phase = '0; e_vld = 0; e_locked = 0; e_ill = 0; e_seq = 0;
            e_pulse = 0; e_rev = '0; e_rev2 = '0;
            return;
        end
        k     = idx_of(c);
        legal = (k >= 0);
        adv   = legal && m_pv && (k == (m_pi + 1) % 8);
        seq   = legal && m_pv && (k != m_pi) && !adv;
        bad   = !legal || seq;
        e_phase = '0;
        if (legal) e_phase[k] = 1'b1;
        e_vld   = legal;
        e_ill   = (e_ill && !clr) || !legal;
        e_seq   = (e_seq && !clr) || seq;
        e_pulse = 0;
        case (m_mode)
            0: begin
                if (bad) m_run = 0;
                else if (adv) begin
                    m_run++;
                    if (m_run == LOCK_CNT) begin
                        m_mode = 1;
                        m_run  = 0;
                    end
                end
            end
            1: begin
                if (bad) m_mode = 2;
                else if (adv && m_pi == 7) begin
                    e_rev++;
                    e_rev2++;
                    e_pulse = 1;
                end
            end
            default: begin
                if (clr) begin
                    m_mode = 0;
                    m_run  = 0;
                end
            end
        endcase
        e_locked = (m_mode == 1);
        if (legal) begin
            m_pi = k;
            m_pv = 1;
        end else begin
            m_pv = 0;
        end
    endtask

    task automatic step(input logic [3:0] c, input logic clr, input logic r);
        jc_in   = c;
        clr_err = clr;
        rst     = r;
        @(posedge clk);
        model(c, clr, r);
        #1;
    endtask

    task automatic test_reset();
        step(4'b1010, 1'b1, 1'b0);
        step(4'b1000, 1'b0, 1'b0);
        checks++;
        if (obs_vec() !== 23'd0)
            $display("FAIL reset_zero: got %h required 0", obs_vec());
        else passed++;
        checks++;
        if (obs_vec() !== exp_vec())
            $display("FAIL reset_model: got %h required %h", obs_vec(), exp_vec());
        else passed++;
    endtask

    task automatic test_lock();
        for (int i = 0; i <= 8; i++) begin
            step(code_of(i), 1'b0, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec())
                $display("FAIL lock_seq[%0d]: got %h required %h", i, obs_vec(), exp_vec());
            else passed++;
            checks++;
            if (locked !== (i == 8) || phase !== (8'd1 << (i % 8)))
                $display("FAIL lock_point[%0d]: locked=%0b phase=%h", i, locked, phase);
            else passed++;
        end
        cur_idx = 0;
    endtask

    task automatic test_revs();
        int pulses = 0;
        for (int i = 0; i < 24; i++) begin
            cur_idx = (cur_idx + 1) % 8;
            step(code_of(cur_idx), 1'b0, 1'b1);
            if (rev_pulse === 1'b1) pulses++;
            checks++;
            if (obs_vec() !== exp_vec())
                $display("FAIL revs[%0d]: got %h required %h", i, obs_vec(), exp_vec());
            else passed++;
        end
        checks++;
        if (rev_cnt !== 8'd3 || pulses != 3)
            $display("FAIL revs_total: rev_cnt=%0d pulses=%0d required 3/3", rev_cnt, pulses);
        else passed++;
    endtask

    task automatic test_illegal();
        step(4'b1010, 1'b0, 1'b1);
        checks++;
        if (phase !== 8'd0 || phase_vld !== 1'b0 || err_illegal !== 1'b1 || locked !== 1'b0)
            $display("FAIL illegal_inject: phase=%h vld=%0b ill=%0b locked=%0b",
                     phase, phase_vld, err_illegal, locked);
        else passed++;
        step(code_of(cur_idx), 1'b1, 1'b1);
        checks++;
        if (err_illegal !== 1'b0 || err_seq !== 1'b0 || rev_cnt !== 8'd3 || obs_vec() !== exp_vec())
            $display("FAIL illegal_clear: got %h required %h", obs_vec(), exp_vec());
        else passed++;
        step(code_of(cur_idx), 1'b0, 1'b1);
        checks++;
        if (obs_vec() !== exp_vec())
            $display("FAIL illegal_after: got %h required %h", obs_vec(), exp_vec());
        else passed++;
    endtask

    task automatic test_skip();
        // relock, then walk to 1100
        for (int i = 0; i < 8 || cur_idx != 2; i++) begin
            cur_idx = (cur_idx + 1) % 8;
            step(code_of(cur_idx), 1'b0, 1'b1);
        end
        checks++;
        if (locked !== 1'b1 || obs_vec() !== exp_vec())
            $display("FAIL skip_relock: got %h required %h", obs_vec(), exp_vec());
        else passed++;
        step(4'b1111, 1'b0, 1'b1);
        cur_idx = 4;
        checks++;
        if (err_seq !== 1'b1 || locked !== 1'b0 || obs_vec() !== exp_vec())
            $display("FAIL skip_fault: got %h required %h", obs_vec(), exp_vec());
        else passed++;
        step(code_of(cur_idx), 1'b1, 1'b1);
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) cur_idx = (cur_idx + 1) % 8;
            for (int h = 0; h < 4; h++) begin
                step(code_of(cur_idx), 1'b0, 1'b1);
                checks++;
                if (obs_vec() !== exp_vec() || locked !== (k >= 8))
                    $display("FAIL skip_holds[%0d.%0d]: got %h required %h", k, h, obs_vec(), exp_vec());
                else passed++;
            end
        end
    endtask

    task automatic test_seqerr_at_lock();
        step(code_of(0), 1'b0, 1'b0);
        for (int i = 0; i <= 7; i++) step(code_of(i), 1'b0, 1'b1);
        step(code_of(3), 1'b0, 1'b1);
        checks++;
        if (locked !== 1'b0 || err_seq !== 1'b1 || obs_vec() !== exp_vec())
            $display("FAIL seqerr_no_lock: got %h required %h", obs_vec(), exp_vec());
        else passed++;
        cur_idx = 3;
        for (int k = 1; k <= 8; k++) begin
            cur_idx = (cur_idx + 1) % 8;
            step(code_of(cur_idx), 1'b0, 1'b1);
            checks++;
            if (locked !== (k == 8) || obs_vec() !== exp_vec())
                $display("FAIL seqerr_recount[%0d]: got %h required %h", k, obs_vec(), exp_vec());
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        step(code_of(0), 1'b0, 1'b0);
        cur_idx = 0;
        step(code_of(0), 1'b0, 1'b1);
        for (int i = 0; i < 8 + 40; i++) begin
            cur_idx = (cur_idx + 1) % 8;
            step(code_of(cur_idx), 1'b0, 1'b1);
        end
        checks++;
        if (locked !== 1'b1 || rev_cnt !== 8'd5 || rev_cnt2 !== 2'd1 || obs_vec() !== exp_vec())
            $display("FAIL rev_wrap: rev=%0d rev2=%0d locked=%0b", rev_cnt, rev_cnt2, locked);
        else passed++;
        cur_idx = (cur_idx + 1) % 8;
        step(code_of(cur_idx), 1'b1, 1'b0);
        checks++;
        if (obs_vec() !== 23'd0)
            $display("FAIL reset_mid: got %h required 0", obs_vec());
        else passed++;
        step(code_of(cur_idx + 2), 1'b0, 1'b1);
        checks++;
        if (err_seq !== 1'b0 || obs_vec() !== exp_vec())
            $display("FAIL reset_release: got %h required %h", obs_vec(), exp_vec());
        else passed++;
        cur_idx = (cur_idx + 2) % 8;
    endtask

    task automatic test_random();
        int r;
        logic [3:0] c;
        logic clr, rr;
        int bad = 0;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 50)      begin cur_idx = (cur_idx + 1) % 8; c = code_of(cur_idx); end
            else if (r < 90) c = code_of(cur_idx);
            else if (r < 94) c = illegal_code($urandom_range(0, 7));
            else if (r < 98) begin cur_idx = $urandom_range(0, 7); c = code_of(cur_idx); end
            else             begin cur_idx = (cur_idx + 1) % 8; c = code_of(cur_idx); end
            clr = ($urandom_range(0, 99) < 6);
            rr  = ($urandom_range(0, 499) != 0);
            step(c, clr, rr);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                if (bad <= 10)
                    $display("FAIL random[%0d]: got %h required %h", i, obs_vec(), exp_vec());
            end else passed++;
        end
    endtask

    initial begin
        rst = 1'b0; jc_in = 4'b0000; clr_err = 1'b0;
        cur_idx = 0;
        model(4'b0000, 1'b0, 1'b0);
        test_reset();
        test_lock();
        test_revs();
        test_illegal();
        test_skip();
        test_seqerr_at_lock();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/johnson_phase_monitor.md
JOHNSON_PHASE_MONITOR -- requirements
Module: johnson_phase_monitor

Interface
REQ-001 Parameter LOCK_CNT, default 8: number of consecutive legal advances required to declare lock (range 1..15).
REQ-002 Parameter REV_W, default 8: width of the revolution counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low: when rst=0 at a clk rising edge, all registers take their reset values.
REQ-005 jc_in  input  4  code from the upstream 4-bit Johnson counter, sampled every cycle.
REQ-006 clr_err  input  1  clears the sticky error flags and releases the FAULT state.
REQ-007 phase  output  8  one-hot decoded phase index.
REQ-008 phase_vld  output  1  the current sample is a legal Johnson code.
REQ-009 locked  output  1  the FSM is in LOCKED.
REQ-010 err_illegal  output  1  sticky flag: a non-Johnson code was seen.
REQ-011 err_seq  output  1  sticky flag: a legal code that is not hold or +1 was seen.
REQ-012 rev_cnt  output  REV_W  number of completed revolutions while locked.
REQ-013 rev_pulse  output  1  one-cycle strobe on each counted revolution.

Function
REQ-014 Legal code to index mapping: 0000=0, 1000=1, 1100=2, 1110=3, 1111=4, 0111=5, 0011=6, 0001=7; the other 8 codes are illegal.
REQ-015 All outputs are registered, with 1-cycle latency from the jc_in sample to the outputs.
REQ-016 Legal sample: phase = 1<<index and phase_vld=1. Illegal sample: phase=0 and phase_vld=0.
REQ-017 The block holds prev_idx and prev_vld. Each legal sample loads prev_idx and sets prev_vld. An illegal sample clears prev_vld.
REQ-018 With prev_vld=1, a legal sample is classified as HOLD (idx=prev_idx), ADVANCE (idx=(prev_idx+1) mod 8, so 7->0 wraps), or SEQERR (any other index).
REQ-019 With prev_vld=0, a legal sample is neither ADVANCE nor SEQERR and only loads prev_idx.
REQ-020 Any illegal sample sets err_illegal. Any SEQERR sets err_seq. Both flags stay set until clr_err.
REQ-021 clr_err=1 clears both flags, except that a detection in the same cycle wins and the flag stays 1.
REQ-022 The FSM has three states: SEARCH, LOCKED and FAULT. The reset state is SEARCH.
REQ-023 SEARCH behaviour:
 - Each ADVANCE increments the 4-bit adv_cnt.
 - HOLD leaves adv_cnt unchanged.
 - An illegal sample or SEQERR clears adv_cnt to 0.
 - When an ADVANCE makes adv_cnt equal LOCK_CNT, the FSM goes to LOCKED and adv_cnt clears.
REQ-024 LOCKED: an illegal sample or SEQERR goes to FAULT. HOLD and ADVANCE stay in LOCKED.
REQ-025 FAULT: stay in FAULT until clr_err=1, then go to SEARCH with adv_cnt=0. Samples in the exit cycle still update prev_idx/prev_vld and the flags, but do not count toward lock.
REQ-026 locked=1 exactly when the registered state is LOCKED.
REQ-027 The revolution counter works as follows:
 - In LOCKED, an ADVANCE from index 7 to index 0 increments rev_cnt modulo 2^REV_W and asserts rev_pulse for 1 cycle.
 - There is no increment in SEARCH or FAULT.
 - The transition from SEARCH into LOCKED is never itself counted.
REQ-028 rev_cnt holds its value through FAULT and clr_err and is cleared only by reset.
REQ-029 Simultaneous events: an error that occurs on the same sample as lock qualification takes priority and clears adv_cnt, so no lock is declared.

Reset
REQ-030 When rst=0 at an edge, the following take their reset values:
 - phase=0, phase_vld=0, locked=0
 - err_illegal=0, err_seq=0
 - rev_cnt=0, rev_pulse=0
 - state=SEARCH, adv_cnt=0, prev_vld=0, prev_idx=0
REQ-031 Reset asserted mid-operation, including in LOCKED or FAULT, overrides all other inputs, clr_err included. The first sample after release is treated as having prev_vld=0.

Verification (LOCK_CNT=8, REV_W=8)
REQ-032 Clean sequence 0000,1000,...,0001,0000 for 8 advances -> locked=1 one cycle after the 8th advance sample, and phase tracks index with 1-cycle lag.
REQ-033 Locked, 3 full revolutions -> rev_cnt=3, with exactly 3 single-cycle rev_pulse strobes each one cycle after the 0001->0000 sample.
REQ-034 Locked, inject 1010 -> phase=0, phase_vld=0, err_illegal=1, locked=0 (FAULT); then clr_err=1 -> flags 0 and state SEARCH, with rev_cnt unchanged.
REQ-035 Locked at 1100, inject 1111 (skip) -> err_seq=1 and FAULT; then hold at each code for 4 cycles in SEARCH -> adv_cnt unaffected by holds.
REQ-036 In SEARCH after 7 advances, a SEQERR on the 8th sample -> no lock and adv_cnt=0.
REQ-037 rst=0 for 1 cycle while locked with rev_cnt=5 -> all outputs 0 next cycle. REV_W=2 with 5 revolutions -> rev_cnt wraps to 1.
